// File: rtl/sd_clock_ctrl.sv
// SD card clock sequencer: brings the divider up, reloads divisors safely and
// gates the divided SD clock on/off only while it is low.
module sd_clock_ctrl #(
    parameter int DIV_W         = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             AXI_CLOCK,
    input  logic             AXI_RST,
    input  logic             int_clk_en,
    input  logic             sd_clk_en,
    input  logic [DIV_W-1:0] divisor_in,
    input  logic             clk_pause_req,
    input  logic             div_stable,
    input  logic             sd_clk_in,
    output logic [DIV_W-1:0] div_divisor,
    output logic             div_run,
    output logic             sd_clk_gate,
    output logic             Internal_clk_stable,
    output logic             busy
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_OFF,
        S_START,
        S_STABLE,
        S_ENABLING,
        S_RUNNING,
        S_STOPPING,
        S_RELOAD
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] settle_cnt;
    logic             divisor_differs;

    assign divisor_differs = (divisor_in != div_divisor);

    // All outputs are registered alongside the state so they change on the
    // same edge as the transition that implies them.
    always_ff @(posedge AXI_CLOCK or posedge AXI_RST) begin
        if (AXI_RST) begin
            state               <= S_OFF;
            settle_cnt          <= '0;
            div_divisor         <= '0;
            div_run             <= 1'b0;
            sd_clk_gate         <= 1'b0;
            Internal_clk_stable <= 1'b0;
            busy                <= 1'b0;
        end else if (!int_clk_en && state != S_OFF) begin
            // Host abort: the gate drops at once even if the card clock is high.
            state               <= S_OFF;
            settle_cnt          <= '0;
            div_run             <= 1'b0;
            sd_clk_gate         <= 1'b0;
            Internal_clk_stable <= 1'b0;
            busy                <= 1'b0;
        end else begin
            case (state)
                S_OFF: begin
                    div_divisor <= divisor_in;
                    if (int_clk_en) begin
                        state      <= S_START;
                        settle_cnt <= '0;
                        div_run    <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                S_START: begin
                    if (!div_stable) begin
                        settle_cnt <= '0;
                    end else if (settle_cnt == CNT_LAST) begin
                        state               <= S_STABLE;
                        settle_cnt          <= '0;
                        Internal_clk_stable <= 1'b1;
                        busy                <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                S_STABLE: begin
                    if (sd_clk_en && !clk_pause_req) begin
                        state <= S_ENABLING;
                        busy  <= 1'b1;
                    end else if (divisor_differs) begin
                        state               <= S_RELOAD;
                        div_run             <= 1'b0;
                        Internal_clk_stable <= 1'b0;
                        busy                <= 1'b1;
                    end
                end
                S_ENABLING: begin
                    if (!sd_clk_in) begin
                        state       <= S_RUNNING;
                        sd_clk_gate <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                S_RUNNING: begin
                    if (!sd_clk_en || clk_pause_req || divisor_differs) begin
                        state <= S_STOPPING;
                        busy  <= 1'b1;
                    end
                end
                S_STOPPING: begin
                    // A pending pause is not remembered here; STABLE re-evaluates it.
                    if (!sd_clk_in) begin
                        sd_clk_gate <= 1'b0;
                        if (divisor_differs) begin
                            state               <= S_RELOAD;
                            div_run             <= 1'b0;
                            Internal_clk_stable <= 1'b0;
                        end else begin
                            state <= S_STABLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                S_RELOAD: begin
                    div_divisor <= divisor_in;
                    state       <= S_START;
                    settle_cnt  <= '0;
                    div_run     <= 1'b1;
                end
                default: begin
                    state               <= S_OFF;
                    settle_cnt          <= '0;
                    div_run             <= 1'b0;
                    sd_clk_gate         <= 1'b0;
                    Internal_clk_stable <= 1'b0;
                    busy                <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_clock_ctrl.sv
// Directed self-checking bench for sd_clock_ctrl; sd_clk_in and div_stable are
// driven by hand so every gate edge lands on a known cycle.
module tb_sd_clock_ctrl;

    localparam int DIV_W = 8;

    logic             AXI_CLOCK = 1'b0;
    logic             AXI_RST = 1'b0;
    logic             int_clk_en = 1'b0;
    logic             sd_clk_en = 1'b0;
    logic [DIV_W-1:0] divisor_in = '0;
    logic             clk_pause_req = 1'b0;
    logic             div_stable = 1'b0;
    logic             sd_clk_in = 1'b0;
    logic [DIV_W-1:0] div_divisor;
    logic             div_run;
    logic             sd_clk_gate;
    logic             Internal_clk_stable;
    logic             busy;

    int errors = 0;
    int checks = 0;

    sd_clock_ctrl #(.DIV_W(DIV_W), .SETTLE_CYCLES(4)) dut (
        .AXI_CLOCK(AXI_CLOCK),
        .AXI_RST(AXI_RST),
        .int_clk_en(int_clk_en),
        .sd_clk_en(sd_clk_en),
        .divisor_in(divisor_in),
        .clk_pause_req(clk_pause_req),
        .div_stable(div_stable),
        .sd_clk_in(sd_clk_in),
        .div_divisor(div_divisor),
        .div_run(div_run),
        .sd_clk_gate(sd_clk_gate),
        .Internal_clk_stable(Internal_clk_stable),
        .busy(busy)
    );

    always #5 AXI_CLOCK = ~AXI_CLOCK;

    // Outputs are sampled and inputs changed 1 time unit after each rising edge.
    task automatic tick();
        @(posedge AXI_CLOCK);
        #1;
    endtask

    // Flag vector {gate, run, stable, busy}
    task automatic test_reset();
        AXI_RST = 1'b1;
        #1;
        checks++;
        if ({sd_clk_gate, div_run, Internal_clk_stable, busy} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_flags got=%b want=0000",
                     {sd_clk_gate, div_run, Internal_clk_stable, busy});
        end
        checks++;
        if (div_divisor !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_divisor got=%0d want=0", div_divisor);
        end
        tick();
        tick();
        AXI_RST = 1'b0;
    endtask

    task automatic test_startup();
        divisor_in = 8'd2;
        int_clk_en = 1'b1;
        tick();
        checks++;
        if ({sd_clk_gate, div_run, Internal_clk_stable, busy} !== 4'b0101) begin
            errors++;
            $display("[TB] FAIL start_flags got=%b want=0101",
                     {sd_clk_gate, div_run, Internal_clk_stable, busy});
        end
        checks++;
        if (div_divisor !== 8'd2) begin
            errors++;
            $display("[TB] FAIL start_divisor got=%0d want=2", div_divisor);
        end
        tick();
        tick();
        div_stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({sd_clk_gate, Internal_clk_stable} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL settle_%0d got gate,stable=%b want=00", i,
                         {sd_clk_gate, Internal_clk_stable});
            end
        end
        tick();
        checks++;
        if ({sd_clk_gate, div_run, Internal_clk_stable, busy} !== 4'b0110) begin
            errors++;
            $display("[TB] FAIL stable_rise got=%b want=0110",
                     {sd_clk_gate, div_run, Internal_clk_stable, busy});
        end
    endtask

    task automatic test_enable();
        sd_clk_in = 1'b1;
        sd_clk_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({sd_clk_gate, busy} !== 2'b01) begin
                errors++;
                $display("[TB] FAIL enable_wait_%0d got gate,busy=%b want=01", i,
                         {sd_clk_gate, busy});
            end
        end
        sd_clk_in = 1'b0;
        tick();
        checks++;
        if ({sd_clk_gate, div_run, Internal_clk_stable, busy} !== 4'b1110) begin
            errors++;
            $display("[TB] FAIL enable_gate got=%b want=1110",
                     {sd_clk_gate, div_run, Internal_clk_stable, busy});
        end
    endtask

    task automatic test_divisor_change();
        sd_clk_in = 1'b1;
        divisor_in = 8'd9;
        tick();
        tick();
        checks++;
        if ({sd_clk_gate, busy} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL stop_hold_high got gate,busy=%b want=11", {sd_clk_gate, busy});
        end
        sd_clk_in = 1'b0;
        tick();
        checks++;
        if ({sd_clk_gate, div_run, Internal_clk_stable, busy} !== 4'b0001 || div_divisor !== 8'd2) begin
            errors++;
            $display("[TB] FAIL reload_cycle got=%b div=%0d want=0001 div=2",
                     {sd_clk_gate, div_run, Internal_clk_stable, busy}, div_divisor);
        end
        tick();
        checks++;
        if ({sd_clk_gate, div_run, Internal_clk_stable, busy} !== 4'b0101 || div_divisor !== 8'd9) begin
            errors++;
            $display("[TB] FAIL restart got=%b div=%0d want=0101 div=9",
                     {sd_clk_gate, div_run, Internal_clk_stable, busy}, div_divisor);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({Internal_clk_stable, busy} !== 2'b01) begin
                errors++;
                $display("[TB] FAIL resettle_%0d got stable,busy=%b want=01", i,
                         {Internal_clk_stable, busy});
            end
        end
        tick();
        checks++;
        if ({sd_clk_gate, Internal_clk_stable} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL restable got gate,stable=%b want=01", {sd_clk_gate, Internal_clk_stable});
        end
        tick();
        tick();
        checks++;
        if ({sd_clk_gate, div_run, Internal_clk_stable, busy} !== 4'b1110) begin
            errors++;
            $display("[TB] FAIL reenable got=%b want=1110",
                     {sd_clk_gate, div_run, Internal_clk_stable, busy});
        end
    endtask

    task automatic test_pause();
        clk_pause_req = 1'b1;
        sd_clk_in = 1'b1;
        tick();
        checks++;
        if ({sd_clk_gate, busy} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL pause_stopping got gate,busy=%b want=11", {sd_clk_gate, busy});
        end
        sd_clk_in = 1'b0;
        tick();
        checks++;
        if ({sd_clk_gate, div_run, Internal_clk_stable, busy} !== 4'b0110 || div_divisor !== 8'd9) begin
            errors++;
            $display("[TB] FAIL pause_stopped got=%b div=%0d want=0110 div=9",
                     {sd_clk_gate, div_run, Internal_clk_stable, busy}, div_divisor);
        end
        for (int i = 0; i < 18; i++) begin
            tick();
            checks++;
            if ({sd_clk_gate, Internal_clk_stable} !== 2'b01) begin
                errors++;
                $display("[TB] FAIL pause_hold_%0d got gate,stable=%b want=01", i,
                         {sd_clk_gate, Internal_clk_stable});
            end
        end
        clk_pause_req = 1'b0;
        tick();
        checks++;
        if ({sd_clk_gate, busy} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL pause_release got gate,busy=%b want=01", {sd_clk_gate, busy});
        end
        tick();
        checks++;
        if ({sd_clk_gate, busy} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL pause_resume got gate,busy=%b want=10", {sd_clk_gate, busy});
        end
    endtask

    task automatic test_abort();
        sd_clk_in = 1'b1;
        int_clk_en = 1'b0;
        tick();
        checks++;
        if ({sd_clk_gate, div_run, Internal_clk_stable, busy} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL abort got=%b want=0000",
                     {sd_clk_gate, div_run, Internal_clk_stable, busy});
        end
        divisor_in = 8'd5;
        tick();
        checks++;
        if (div_divisor !== 8'd5 || div_run !== 1'b0) begin
            errors++;
            $display("[TB] FAIL off_tracks_divisor got div=%0d run=%b want div=5 run=0",
                     div_divisor, div_run);
        end
    endtask

    task automatic test_reset_in_reload();
        sd_clk_en = 1'b0;
        sd_clk_in = 1'b0;
        div_stable = 1'b1;
        int_clk_en = 1'b1;
        repeat (5) tick();
        checks++;
        if ({div_run, Internal_clk_stable, busy} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL pre_reload_stable got=%b want=110", {div_run, Internal_clk_stable, busy});
        end
        divisor_in = 8'd7;
        tick();
        checks++;
        if ({div_run, Internal_clk_stable, busy} !== 3'b001 || div_divisor !== 8'd5) begin
            errors++;
            $display("[TB] FAIL idle_reload got=%b div=%0d want=001 div=5",
                     {div_run, Internal_clk_stable, busy}, div_divisor);
        end
        #2;
        AXI_RST = 1'b1;
        #1;
        checks++;
        if ({sd_clk_gate, div_run, Internal_clk_stable, busy} !== 4'b0000 || div_divisor !== 8'd0) begin
            errors++;
            $display("[TB] FAIL async_reset got=%b div=%0d want=0000 div=0",
                     {sd_clk_gate, div_run, Internal_clk_stable, busy}, div_divisor);
        end
        AXI_RST = 1'b0;
        tick();
        checks++;
        if ({div_run, Internal_clk_stable, busy} !== 3'b101 || div_divisor !== 8'd7) begin
            errors++;
            $display("[TB] FAIL post_reset_start got=%b div=%0d want=101 div=7",
                     {div_run, Internal_clk_stable, busy}, div_divisor);
        end
        tick();
        tick();
        div_stable = 1'b0;
        tick();
        div_stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (Internal_clk_stable !== 1'b0) begin
                errors++;
                $display("[TB] FAIL counter_clear_%0d got stable=%b want=0", i, Internal_clk_stable);
            end
        end
        tick();
        checks++;
        if ({div_run, Internal_clk_stable, busy} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL post_reset_stable got=%b want=110", {div_run, Internal_clk_stable, busy});
        end
    endtask

    initial begin
        $display("[TB] sd_clock_ctrl directed tests start");
        test_reset();
        test_startup();
        test_enable();
        test_divisor_change();
        test_pause();
        test_abort();
        test_reset_in_reload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
